// File: rtl/tlp_pack_pkg.sv
// Shared types for the TLP packer and the Ethernet/IP/UDP encapsulator:
// the 74-bit TLP FIFO word, the packer's buffer entry and FSM state.
package tlp_pack_pkg;

   localparam int unsigned TLP_FIFO_W = 74;
   localparam int unsigned TLP_BUF_W  = 73;

   typedef struct packed {
      logic [7:0]  tkeep;
      logic [63:0] tdata;
      logic        tlast;
      logic        tuser;
   } tlp_fifo_word_t;

   typedef struct packed {
      logic [7:0]  tkeep;
      logic [63:0] tdata;
      logic        tuser;
   } tlp_buf_word_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_DROP,
      ST_WAIT,
      ST_DRAIN
   } pack_state_t;

   // Zero every byte lane whose keep bit is clear (keep[0] covers data[7:0]).
   function automatic logic [63:0] keep_mask(input logic [63:0] data, input logic [7:0] keep);
      logic [63:0] masked;
      masked = '0;
      for (int b = 0; b < 8; b++) begin
         if (keep[b]) masked[b*8 +: 8] = data[b*8 +: 8];
      end
      return masked;
   endfunction

endpackage

// File: rtl/tlp_pack_buf.sv
// Packet buffer for tlp_pack: simple dual-port RAM, one write and one
// registered read per cycle.
module tlp_pack_buf
   import tlp_pack_pkg::*;
#(
   parameter int unsigned depth  = 32,
   parameter int unsigned addr_w = 5
) (
   input  logic                clk,
   input  logic                we,
   input  logic [addr_w-1:0]   waddr,
   input  tlp_buf_word_t       wdata,
   input  logic [addr_w-1:0]   raddr,
   output tlp_buf_word_t       rdata
);

   tlp_buf_word_t mem [depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/tlp_pack.sv
// Store-and-forward TLP packer: buffers a whole packet, then commits it to the
// TLP FIFO only once there is room for all of it. TLP_PACK_STATS_EN adds counters.
module tlp_pack
   import tlp_pack_pkg::*;
#(
   parameter int unsigned min_words   = 2,
   parameter int unsigned max_words   = 32,
   parameter int unsigned fifo_depth  = 512,
   parameter int unsigned count_slack = 4
) (
   input  logic                  clk156,
   input  logic                  sys_rst,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [63:0]           s_axis_tdata,
   input  logic [7:0]            s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  wr_en,
   output logic [TLP_FIFO_W-1:0] din,
   input  logic                  full,
   input  logic [9:0]            wr_data_count
`ifdef TLP_PACK_STATS_EN
   ,
   output logic [31:0]           pkt_count,
   output logic [31:0]           drop_count
`endif
);

   localparam int unsigned CW     = $clog2(max_words + 1);
   localparam int unsigned AW     = $clog2(max_words);
   localparam int unsigned FREE_W = 11;

   pack_state_t    state;
   logic           rdy;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  len;
   logic [CW-1:0]  plen;
   logic [CW-1:0]  nx;
   logic           err;
   logic           word_vld;
   tlp_fifo_word_t word_q;

   logic           beat;
   logic           err_in;
   logic [CW-1:0]  fill_len;
   logic [CW-1:0]  fill_plen;
   logic [FREE_W-1:0] free_words;
   logic [FREE_W-1:0] need_words;
   logic           free_ok;
   logic           load;
   logic           drop_evt;
   logic           commit_evt;
   logic [CW-1:0]  rd_next;
   tlp_fifo_word_t next_word;

   logic           ram_we;
   logic [AW-1:0]  ram_waddr;
   logic [AW-1:0]  ram_raddr;
   tlp_buf_word_t  ram_wdata;
   tlp_buf_word_t  ram_rdata;

   // Ready is a registered flag, forced low while reset is asserted.
   assign s_axis_tready = rdy & ~sys_rst;
   assign beat          = s_axis_tvalid & s_axis_tready;
   assign wr_en         = word_vld & ~full;
   assign din           = word_q;

   assign err_in    = ((state == ST_FILL) & err) | s_axis_tuser;
   assign fill_len  = (state == ST_IDLE) ? CW'(1) : cnt + CW'(1);
   assign fill_plen = (fill_len < CW'(min_words)) ? CW'(min_words) : fill_len;

   // 11-bit free-space test so fifo_depth - count never wraps.
   assign free_words = FREE_W'(fifo_depth) - FREE_W'(wr_data_count);
   assign need_words = FREE_W'(plen) + FREE_W'(count_slack);
   assign free_ok    = free_words >= need_words;

   // Output register takes the next word whenever it is empty or being written.
   assign load       = (state == ST_DRAIN) && (nx < plen) && (!word_vld || !full);
   assign commit_evt = load && (nx == plen - CW'(1));
   assign drop_evt   = beat && s_axis_tlast &&
                       ((state == ST_DROP) || ((state == ST_FILL) && (cnt == CW'(max_words))));

   assign ram_we    = beat && ((state == ST_IDLE) || ((state == ST_FILL) && (cnt != CW'(max_words))));
   assign ram_waddr = (state == ST_IDLE) ? '0 : AW'(cnt);
   assign ram_wdata = {s_axis_tkeep, s_axis_tdata, s_axis_tuser};

   // RAM output always holds word nx; prefetch nx+1 on the edge that loads nx.
   always_comb begin
      rd_next = '0;
      if (state == ST_DRAIN) rd_next = load ? nx + CW'(1) : nx;
      ram_raddr = (rd_next >= CW'(max_words)) ? '0 : AW'(rd_next);
   end

   always_comb begin
      next_word = '0;
      if (nx < len) begin
         next_word.tdata = ram_rdata.tdata;
         next_word.tkeep = ram_rdata.tkeep;
         if ((len < CW'(min_words)) && (nx == len - CW'(1))) begin
            next_word.tdata = keep_mask(ram_rdata.tdata, ram_rdata.tkeep);
            next_word.tkeep = 8'hFF;
         end
      end else begin
         next_word.tkeep = 8'hFF;
      end
      if (nx == plen - CW'(1)) begin
         next_word.tlast = 1'b1;
         next_word.tuser = err | ((nx < len) & ram_rdata.tuser);
      end
   end

   tlp_pack_buf #(
      .depth  (max_words),
      .addr_w (AW)
   ) u_buf (
      .clk   (clk156),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk156 or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= ST_IDLE;
         rdy      <= 1'b1;
         cnt      <= '0;
         len      <= '0;
         plen     <= '0;
         nx       <= '0;
         err      <= 1'b0;
         word_vld <= 1'b0;
         word_q   <= '0;
      end else begin
         if (load) begin
            word_q   <= next_word;
            word_vld <= 1'b1;
            nx       <= nx + CW'(1);
         end else if (wr_en) begin
            word_vld <= 1'b0;
         end

         case (state)
            ST_IDLE, ST_FILL: begin
               if (beat) begin
                  if ((state == ST_FILL) && (cnt == CW'(max_words))) begin
                     state <= s_axis_tlast ? ST_IDLE : ST_DROP;
                  end else if (s_axis_tlast) begin
                     len   <= fill_len;
                     plen  <= fill_plen;
                     err   <= err_in;
                     rdy   <= 1'b0;
                     state <= ST_WAIT;
                  end else begin
                     cnt   <= fill_len;
                     err   <= err_in;
                     state <= ST_FILL;
                  end
               end
            end
            ST_DROP: begin
               if (drop_evt) state <= ST_IDLE;
            end
            ST_WAIT: begin
               if (!word_vld && free_ok) begin
                  nx    <= '0;
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (commit_evt) begin
                  rdy   <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: begin
               rdy   <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef TLP_PACK_STATS_EN
   always_ff @(posedge clk156 or posedge sys_rst) begin
      if (sys_rst) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         if (commit_evt) pkt_count  <= pkt_count + 32'd1;
         if (drop_evt)   drop_count <= drop_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tlp_pack.sv
// Bench for tlp_pack: directed and random packets checked against a
// packet-level model of the expected FIFO word stream.
module tb_tlp_pack;

   localparam int unsigned MINW  = 2;
   localparam int unsigned MAXW  = 32;
   localparam int unsigned DEPTH = 512;
   localparam int unsigned SLACK = 4;

   logic        clk156 = 1'b0;
   logic        sys_rst = 1'b1;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tuser = 1'b0;
   logic        wr_en;
   logic [73:0] din;
   logic        full = 1'b0;
   logic [9:0]  wr_data_count = '0;
`ifdef TLP_PACK_STATS_EN
   logic [31:0] pkt_count;
   logic [31:0] drop_count;
`endif

   logic [63:0] pd[$];
   logic [7:0]  pk[$];
   logic        pu[$];
   logic [73:0] exp_q[$];
   logic [73:0] got_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          exp_pkts = 0;
   int          exp_drops = 0;
   bit          rand_full = 1'b0;
   int          lat;

   always #5 clk156 = ~clk156;

   tlp_pack #(
      .min_words   (MINW),
      .max_words   (MAXW),
      .fifo_depth  (DEPTH),
      .count_slack (SLACK)
   ) dut (
      .clk156        (clk156),
      .sys_rst       (sys_rst),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .wr_en         (wr_en),
      .din           (din),
      .full          (full),
      .wr_data_count (wr_data_count)
`ifdef TLP_PACK_STATS_EN
      ,
      .pkt_count     (pkt_count),
      .drop_count    (drop_count)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // FIFO side: collect written words, and wr_en must never pulse while full.
   always @(negedge clk156) begin
      if (wr_en) got_q.push_back(din);
      if (full) chk("wr_en_while_full", wr_en, 1'b0);
   end

   always @(posedge clk156) begin
      #1;
      full = rand_full && ($urandom_range(0, 2) == 0);
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic make_pkt(input int n, input int err_beat, input logic [7:0] last_keep);
      pd.delete(); pk.delete(); pu.delete();
      for (int i = 0; i < n; i++) begin
         pd.push_back({$urandom(), $urandom()});
         pk.push_back((i == n - 1) ? last_keep : 8'hFF);
         pu.push_back(i == err_beat);
      end
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
      bit acc = 1'b0;
      int n = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
      while (!acc && n < 1000) begin
         @(negedge clk156);
         acc = s_axis_tready;
         @(posedge clk156);
         #1;
         n++;
      end
      s_axis_tvalid = 1'b0;
      if (!acc) chk("beat_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_pkt();
      @(posedge clk156);
      #1;
      got_q.delete();
      foreach (pd[i]) send_beat(pd[i], pk[i], i == pd.size() - 1, pu[i]);
   endtask

   // Expected FIFO words derived from the packet alone.
   function automatic void model();
      int n = pd.size();
      int lw;
      logic err = 1'b0;
      logic [63:0] d;
      logic [7:0] k;
      exp_q.delete();
      if (n > MAXW) begin
         exp_drops++;
         return;
      end
      exp_pkts++;
      lw = (n < MINW) ? MINW : n;
      foreach (pu[i]) err |= pu[i];
      for (int i = 0; i < lw; i++) begin
         d = 64'h0;
         k = 8'hFF;
         if (i < n) begin
            d = pd[i];
            k = pk[i];
            if (n < MINW && i == n - 1) begin
               for (int b = 0; b < 8; b++) if (!k[b]) d[b*8 +: 8] = 8'h00;
               k = 8'hFF;
            end
         end
         exp_q.push_back({k, d, (i == lw - 1), (i == lw - 1) ? err : 1'b0});
      end
   endfunction

   task automatic finish_pkt(input string name);
      int n = 0;
      model();
      while (got_q.size() < exp_q.size() && n < 800) begin
         @(negedge clk156);
         n++;
      end
      repeat (10) @(negedge clk156);
      chk({name, "_words"}, got_q.size(), exp_q.size());
      foreach (exp_q[i]) if (i < got_q.size()) chk($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
   endtask

   task automatic wr_latency(output int l);
      l = 0;
      while (l < 50) begin
         @(negedge clk156);
         if (wr_en) break;
         l++;
      end
   endtask

   initial begin
      @(negedge clk156);
      chk("rst_tready", s_axis_tready, 1'b0);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_din", din, 74'h0);
      repeat (2) @(posedge clk156);
      #1 sys_rst = 1'b0;
      @(negedge clk156);
      chk("idle_tready", s_axis_tready, 1'b1);
`ifdef TLP_PACK_STATS_EN
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_drop_count", drop_count, 0);
`endif

      // 3 beats, partial last keep, empty FIFO
      make_pkt(3, -1, 8'h0F);
      send_pkt();
      wr_latency(lat);
      chk("three_latency", lat, 2);
      finish_pkt("three");

      // 1 beat, padded to min_words
      pd.delete(); pk.delete(); pu.delete();
      pd.push_back(64'h1122334455667788); pk.push_back(8'h0F); pu.push_back(1'b0);
      send_pkt();
      finish_pkt("one");
      if (got_q.size() >= 2) begin
         chk("pad_w0_data", got_q[0][65:2], 64'h0000000055667788);
         chk("pad_w0_keep", got_q[0][73:66], 8'hFF);
         chk("pad_w1", got_q[1], {8'hFF, 64'h0, 1'b1, 1'b0});
      end

      // over-length packets, then legal ones
      make_pkt(33, -1, 8'hFF); send_pkt(); finish_pkt("drop33");
      make_pkt(2, -1, 8'h07);  send_pkt(); finish_pkt("after_drop");
      make_pkt(36, 5, 8'hFF);  send_pkt(); finish_pkt("drop36");
      make_pkt(32, -1, 8'h01); send_pkt(); finish_pkt("max32");

      // FIFO nearly full: hold until free space covers L + slack
      wr_data_count = 10'd508;
      make_pkt(3, -1, 8'h3F);
      send_pkt();
      repeat (10) begin
         @(negedge clk156);
         chk("hold_wr_en", wr_en, 1'b0);
         chk("hold_tready", s_axis_tready, 1'b0);
      end
      @(posedge clk156);
      #1 wr_data_count = 10'd505;
      wr_latency(lat);
      chk("count_latency", lat, 2);
      wr_data_count = 10'd0;
      finish_pkt("cnt508");

      // capture error on beat 2 of 4
      make_pkt(4, 1, 8'hFF); send_pkt(); finish_pkt("tuser");

      // reset in the middle of FILL
      make_pkt(5, -1, 8'h01);
      @(posedge clk156);
      #1;
      got_q.delete();
      send_beat(pd[0], pk[0], 1'b0, 1'b0);
      send_beat(pd[1], pk[1], 1'b0, 1'b0);
      sys_rst = 1'b1;
      @(negedge clk156);
      chk("midrst_tready", s_axis_tready, 1'b0);
      chk("midrst_wr_en", wr_en, 1'b0);
      @(posedge clk156);
      #1 sys_rst = 1'b0;
      repeat (10) @(negedge clk156);
      chk("midrst_words", got_q.size(), 0);
      exp_pkts = 0;
      exp_drops = 0;
      send_pkt();
      finish_pkt("after_rst");

      // random packets with random FIFO backpressure
      rand_full = 1'b1;
      for (int p = 0; p < 30; p++) begin
         int n;
         n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(33, 36)) : int'($urandom_range(1, 32));
         make_pkt(n, -1, 8'($urandom_range(1, 255)));
         foreach (pu[i]) pu[i] = ($urandom_range(0, 7) == 0);
         send_pkt();
         finish_pkt($sformatf("rnd%0d", p));
      end
      rand_full = 1'b0;
      repeat (3) @(negedge clk156);

`ifdef TLP_PACK_STATS_EN
      chk("pkt_count", pkt_count, exp_pkts);
      chk("drop_count", drop_count, exp_drops);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tlp_pack.md
# tlp_pack

Store-and-forward packer that sits directly upstream of the Ethernet/IP/UDP encapsulator. It accepts a 64-bit AXI-Stream of captured TLPs and buffers each packet whole. It then writes the packet into the 74-bit TLP FIFO only once the FIFO has room for all of it. The encapsulator reads every data beat unconditionally once the FIFO is non-empty, so nothing may become visible there until the complete packet is committed.

## Interface

- `min_words`, 2, minimum words per packet in the FIFO; shorter packets are zero-padded.
- `max_words`, 32, internal buffer depth in words; longer packets are dropped.
- `fifo_depth`, 512, depth of the downstream TLP FIFO.
- `count_slack`, 4, extra free words required to cover FIFO count latency.
- `clk156` input 1: sole clock.
- `sys_rst` input 1: asynchronous, active-high reset.
- `s_axis_tvalid` input 1: TLP beat valid.
- `s_axis_tready` output 1: beat accepted when high together with `s_axis_tvalid`.
- `s_axis_tdata` input 64: TLP data.
- `s_axis_tkeep` input 8: byte enables; partial only on the tlast beat.
- `s_axis_tlast` input 1: last beat of the TLP.
- `s_axis_tuser` input 1: capture error.
- `wr_en` output 1: FIFO write strobe.
- `din` output 74: FIFO word {tkeep[73:66], tdata[65:2], tlast[1], tuser[0]}.
- `full` input 1: FIFO full.
- `wr_data_count` input 10: FIFO occupancy in words; may lag writes by up to 2 cycles.

## Operation

State machine:

- **IDLE**
  - `s_axis_tready`=1.
  - First accepted beat is written to buffer[0], count=1.
  - Goes to FILL, or straight to WAIT if that beat has tlast.
- **FILL**
  - `s_axis_tready`=1; each beat goes to buffer[count] and count increments.
  - On tlast: store the length and the OR of all tuser bits, then go to WAIT.
  - If a beat without tlast arrives while count==max_words: discard the buffer, go to DROP.
- **DROP**
  - `s_axis_tready`=1; beats are discarded.
  - On tlast go to IDLE; drop counter +1.
- **WAIT**
  - `s_axis_tready`=0.
  - L = max(len, min_words).
  - Go to DRAIN when fifo_depth − wr_data_count ≥ L + count_slack.
- **DRAIN**
  - `s_axis_tready`=0.
  - One word per cycle: `wr_en` = !full, and the read index advances only when written.
  - Word L−1 carries din[1]=1 and din[0]=error flag; all other words carry din[1:0]=0.
  - After word L−1 go to IDLE; packet counter +1.

Padding (len < min_words):

- The original last word gets tkeep forced to 8'hFF and its disabled bytes zeroed.
- Pad words are data 0, tkeep 8'hFF.

Width rules:

- count, len and the read index are $clog2(max_words+1) bits.
- Free-space arithmetic is done at 11 bits, so there is no wrap.

## Timing

- Reset values:
  - `s_axis_tready`=0 during reset, 1 in the first cycle after release (IDLE).
  - `wr_en`=0.
  - `din`=0.
  - state=IDLE, all counters 0.
- Buffer is a registered-read RAM. Minimum latency is 2 cycles from the tlast acceptance edge to the first `wr_en` (WAIT evaluated, then first word presented) when space is available.
- Throughput: 1 word/cycle in and out. Input stalls for L + 1 cycles per packet.
- `full` during DRAIN: `wr_en` is held low and `din` is held stable; no word is skipped.
- Reset mid-operation:
  - Buffered data is lost.
  - `sys_rst` must also reset the downstream FIFO, so a partially drained packet never survives reset.
- Simultaneous tlast and max_words boundary: a tlast beat at count==max_words−1 is accepted as a legal max-length packet.

## Configuration

- `TLP_PACK_STATS_EN` defined: adds output ports `pkt_count[31:0]` (packets committed) and `drop_count[31:0]` (packets dropped). Both reset to 0 and wrap at 2^32.
- Undefined: neither the ports nor the counters exist; the drop behaviour is identical.

## Structure

- Shared package (used by this block and the encapsulator):
  - `tlp_fifo_word_t`, a 74-bit packed struct {tkeep, tdata, tlast, tuser}.
  - `TLP_FIFO_W = 74`.
- Sub-module `tlp_pack_buf`: simple dual-port RAM, max_words × 73 bits (tkeep + tdata + tuser) with registered read.

## Test plan

- 3-beat TLP, last tkeep=8'h0F, FIFO empty:
  - exactly 3 `wr_en` pulses;
  - din[1]=1 and din[73:66]=8'h0F on the third word only.
- 1-beat TLP with tkeep=8'h0F and data 64'h1122334455667788, min_words=2:
  - word0 data 64'h0000000055667788 with tkeep FF;
  - word1 data 0, tkeep FF, tlast=1.
- 33-beat TLP with max_words=32:
  - no `wr_en`, drop_count=1;
  - the following 2-beat TLP is written correctly.
- wr_data_count=508 with a 3-word packet pending:
  - `wr_en` stays 0 and `s_axis_tready`=0;
  - drain starts 1 cycle after wr_data_count≤505.
- tuser=1 on beat 2 of 4: din[0]=1 on word 4 only.
- `sys_rst` pulsed mid-FILL: no `wr_en`; the next full packet is committed intact.
